sf_rd_packer: RTL and testbench



---
 rtl/sf_rd_packer.sv | 124 ++++++++++++
 tb/tb_sf_rd_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sf_rd_packer.sv
// Drains bytes from the synchronous FIFO and packs LANES of them, little-endian, into one wide word.
// The word leaves on a valid/ready stream. A flush emits the pending partial word with a byte-keep mask.
module sf_rd_packer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_empty,
    input  logic [DATA_W-1:0]        fifo_data,
    output logic                     fifo_r_en,
    input  logic                     flush,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W*LANES-1:0]  m_data,
    output logic [LANES-1:0]         m_keep,
    output logic [15:0]              words_out
);

    localparam int CNT_W = $clog2(LANES) + 1;
    localparam logic [CNT_W-1:0] LANE_FULL = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] LANE_LAST = CNT_W'(LANES - 1);
    localparam logic [CNT_W:0]   TOT_FULL  = (CNT_W + 1)'(LANES);

    // m_valid/m_ready: a word transfers on any rising edge where both are high.
    // While m_valid is high and m_ready is low, m_data and m_keep hold stable.
    logic [CNT_W-1:0]               lane_cnt;
    logic [CNT_W-1:0]               lane_cnt_next;
    logic [CNT_W-2:0]               lane_idx;
    logic                           rd_pending;
    logic                           flush_req;
    logic                           flush_req_next;
    logic [LANES-1:0][DATA_W-1:0]   asm_q;
    logic [LANES-1:0][DATA_W-1:0]   asm_next;
    logic [LANES-1:0][DATA_W-1:0]   word_bytes;
    logic [LANES-1:0]               word_keep;
    logic [CNT_W:0]                 total;
    logic                           out_free;
    logic                           complete;
    logic                           word_load;

    assign out_free = !m_valid || m_ready;
    assign total    = {1'b0, lane_cnt} + {{CNT_W{1'b0}}, rd_pending};
    assign lane_idx = lane_cnt[CNT_W-2:0];
    assign complete = (lane_cnt == LANE_FULL) || (rd_pending && lane_cnt == LANE_LAST);

    // Counting the in-flight byte into total keeps reads from outrunning assembly space.
    assign fifo_r_en = rst_n && !fifo_empty && !flush_req &&
                       ((total < TOT_FULL) || (total == TOT_FULL && out_free));

    always_comb begin
        asm_next       = asm_q;
        lane_cnt_next  = lane_cnt;
        word_bytes     = asm_q;
        word_keep      = '0;
        word_load      = 1'b0;
        flush_req_next = flush_req;

        if (rd_pending && lane_cnt != LANE_FULL) begin
            word_bytes[lane_idx] = fifo_data;
        end

        if (complete && out_free) begin
            word_load = 1'b1;
            word_keep = '1;
            if (rd_pending && lane_cnt == LANE_FULL) begin
                asm_next[0]   = fifo_data;
                lane_cnt_next = CNT_W'(1);
            end else begin
                lane_cnt_next = '0;
            end
        end else if (rd_pending) begin
            asm_next[lane_idx] = fifo_data;
            lane_cnt_next      = lane_cnt + CNT_W'(1);
        end

        // A full assembly is already emitted above; only a partial one needs the masked path.
        if (flush_req && !rd_pending && out_free) begin
            flush_req_next = 1'b0;
            if (lane_cnt != '0 && lane_cnt != LANE_FULL) begin
                word_load     = 1'b1;
                lane_cnt_next = '0;
                for (int i = 0; i < LANES; i++) begin
                    if (CNT_W'(i) < lane_cnt) begin
                        word_keep[i] = 1'b1;
                    end else begin
                        word_bytes[i] = '0;
                    end
                end
            end
        end else if (flush) begin
            flush_req_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_cnt   <= '0;
            asm_q      <= '0;
            rd_pending <= 1'b0;
            flush_req  <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            words_out  <= '0;
        end else begin
            lane_cnt   <= lane_cnt_next;
            asm_q      <= asm_next;
            rd_pending <= fifo_r_en;
            flush_req  <= flush_req_next;
            if (out_free) begin
                m_valid <= word_load;
                if (word_load) begin
                    m_data <= word_bytes;
                    m_keep <= word_keep;
                end
            end
            if (m_valid && m_ready) begin
                words_out <= words_out + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sf_rd_packer.sv
// Self-checking bench for sf_rd_packer: a queue-based FIFO model feeds the packer, and a byte-stream
// reference model fills an expected-word scoreboard. Table vectors and directed sequences cover the corner cases.
module tb_sf_rd_packer;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = DATA_W * LANES;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_r_en;
    logic              flush;
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic [LANES-1:0]  m_keep;
    logic [15:0]       words_out;

    sf_rd_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .words_out  (words_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int hs_total = 0;
    int hs_model = 0;
    logic [DATA_W-1:0] fq[$];
    logic [DATA_W-1:0] acc[$];
    logic [LANES+WORD_W-1:0] exp_q[$];
    int rd_cyc[$];
    int hs_cyc[$];
    logic gap = 1'b0;
    logic force_ne = 1'b1;
    logic fire = 1'b0;
    logic [DATA_W-1:0] pend = '0;
    logic prev_hold = 1'b0;
    logic [LANES+WORD_W-1:0] prev_word = '0;
    logic [WORD_W-1:0] last_data = '0;
    logic [LANES-1:0]  last_keep = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Reference model: every accepted byte joins a list; each LANES bytes form a word, a flush closes a partial.
    task automatic model_emit();
        logic [WORD_W-1:0] w;
        logic [LANES-1:0]  k;
        w = '0;
        k = '0;
        for (int i = 0; i < acc.size(); i++) begin
            w[DATA_W*i +: DATA_W] = acc[i];
            k[i] = 1'b1;
        end
        exp_q.push_back({k, w});
        acc.delete();
    endtask

    always @(posedge clk) begin
        #2;
        fifo_empty = force_ne ? 1'b0 : (gap || fq.size() == 0);
    end

    always @(posedge clk) begin
        if (fire) fifo_data <= pend;
    end

    always @(negedge clk) begin
        cyc++;
        fire = 1'b0;
        if (!rst_n) begin
            check("rd_en_in_reset", fifo_r_en, 0);
            fq.delete();
            acc.delete();
            exp_q.delete();
            hs_model = 0;
            prev_hold = 1'b0;
        end else begin
            check("rd_while_empty", fifo_r_en && fifo_empty, 0);
            if (fifo_r_en && !fifo_empty) begin
                check("fifo_underflow", fq.size() == 0, 0);
                if (fq.size() > 0) begin
                    pend = fq.pop_front();
                    fire = 1'b1;
                    rd_cnt++;
                    rd_cyc.push_back(cyc);
                    acc.push_back(pend);
                    if (acc.size() == LANES) model_emit();
                end
            end
            if (flush && acc.size() > 0) model_emit();
            check("words_out", words_out, hs_model);
            if (prev_hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_word", {m_keep, m_data}, prev_word);
            end
            if (m_valid && m_ready) begin
                check("sb_has_word", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_word", {m_keep, m_data}, exp_q.pop_front());
                hs_model++;
                hs_total++;
                hs_cyc.push_back(cyc);
                last_data = m_data;
                last_keep = m_keep;
            end
            prev_hold = m_valid && !m_ready;
            prev_word = {m_keep, m_data};
        end
    end

    typedef struct {
        int                n;
        logic [63:0]       bytes;
        bit                do_flush;
        int                exp_n;
        logic [WORD_W-1:0] exp_data;
        logic [LANES-1:0]  exp_keep;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int hs0;
        int rd0;
        vecs[0] = '{3, 64'h0000_0000_00A3_A2A1, 1'b1, 1, 32'h00A3A2A1, 4'h7};
        vecs[1] = '{0, 64'h0,                   1'b1, 0, 32'h0,        4'h0};
        vecs[2] = '{4, 64'h0000_0000_C4C3_C2C1, 1'b1, 1, 32'hC4C3C2C1, 4'hF};
        vecs[3] = '{5, 64'h0000_00D5_D4D3_D2D1, 1'b1, 2, 32'h000000D5, 4'h1};

        rst_n = 1'b0;
        flush = 1'b0;
        m_ready = 1'b0;
        fifo_empty = 1'b0;

        // Reset held two cycles with the FIFO claiming data.
        ticks(2);
        rst_n = 1'b1;
        force_ne = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_valid", m_valid, 0);
        check("post_rst_data", m_data, 0);
        check("post_rst_keep", m_keep, 0);
        check("post_rst_words", words_out, 0);
        check("post_rst_rd_en", fifo_r_en, 0);
        tick();

        // Streaming: 8 bytes at full rate.
        m_ready = 1'b1;
        rd_cyc.delete();
        hs_cyc.delete();
        for (int i = 0; i < 8; i++) fq.push_back(DATA_W'(8'h11 * (i + 1)));
        ticks(16);
        check("stream_reads", rd_cyc.size(), 8);
        if (rd_cyc.size() == 8) begin
            check("stream_back_to_back", rd_cyc[7] - rd_cyc[0], 7);
        end
        check("stream_words", hs_cyc.size(), 2);
        if (hs_cyc.size() > 0 && rd_cyc.size() > 3) begin
            check("stream_latency", hs_cyc[0] - rd_cyc[3], 2);
        end
        check("stream_last", last_data, 32'h88776655);
        check("stream_keep", last_keep, 4'hF);
        check("stream_words_out", words_out, 2);

        // Table vectors, all with m_ready high.
        for (int v = 0; v < 4; v++) begin
            hs0 = hs_total;
            for (int i = 0; i < vecs[v].n; i++) fq.push_back(vecs[v].bytes[8*i +: 8]);
            ticks(16);
            if (vecs[v].do_flush) pulse_flush();
            ticks(10);
            check($sformatf("vec%0d_count", v), hs_total - hs0, vecs[v].exp_n);
            if (vecs[v].exp_n > 0) begin
                check($sformatf("vec%0d_data", v), last_data, vecs[v].exp_data);
                check($sformatf("vec%0d_keep", v), last_keep, vecs[v].exp_keep);
            end
        end

        // Backpressure: 12 bytes, downstream stalled.
        m_ready = 1'b0;
        rd0 = rd_cnt;
        hs0 = hs_total;
        for (int i = 0; i < 12; i++) fq.push_back(DATA_W'(8'h21 + i));
        ticks(20);
        check("bp_reads", rd_cnt - rd0, 8);
        check("bp_rd_en_low", fifo_r_en, 0);
        check("bp_valid", m_valid, 1);
        check("bp_first_word", m_data, 32'h24232221);
        m_ready = 1'b1;
        ticks(16);
        check("bp_drained", hs_total - hs0, 3);
        check("bp_last", last_data, 32'h2C2B2A29);

        // Flush while the assembly is full behind a stalled output.
        m_ready = 1'b0;
        hs0 = hs_total;
        for (int i = 0; i < 8; i++) fq.push_back(DATA_W'(8'h61 + i));
        ticks(16);
        pulse_flush();
        ticks(4);
        m_ready = 1'b1;
        ticks(10);
        check("full_flush_count", hs_total - hs0, 2);
        check("full_flush_last", last_data, 32'h68676665);
        check("full_flush_keep", last_keep, 4'hF);

        // Gapped input: empty toggles every cycle.
        hs0 = hs_total;
        for (int i = 0; i < 4; i++) fq.push_back(DATA_W'(i + 1));
        for (int i = 0; i < 16; i++) begin
            gap = ~gap;
            tick();
        end
        gap = 1'b0;
        ticks(4);
        check("gap_count", hs_total - hs0, 1);
        check("gap_word", last_data, 32'h04030201);

        // Reset mid-word: two bytes captured, then discarded.
        fq.push_back(8'h51);
        fq.push_back(8'h52);
        ticks(6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        hs0 = hs_total;
        for (int i = 0; i < 4; i++) fq.push_back(DATA_W'(8'hB1 + i));
        ticks(12);
        check("midrst_count", hs_total - hs0, 1);
        check("midrst_word", last_data, 32'hB4B3B2B1);
        check("midrst_words_out", words_out, 1);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0 && fq.size() < 16) fq.push_back(DATA_W'($urandom_range(0, 255)));
            gap = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        gap = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 200 && fq.size() > 0; i++) tick();
        ticks(4);
        pulse_flush();
        ticks(10);
        check("final_fifo_drained", fq.size(), 0);
        check("final_sb_empty", exp_q.size(), 0);
        check("final_acc_empty", acc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
